clock_timekeeper: RTL and testbench
===================================

Name: clock_timekeeper

Overview:
- Timekeeping stage of the digital clock. Sits directly downstream of the clock divider.
- Consumes the divider's 1 kHz square wave (clkout) and produces BCD hours, minutes and seconds for the display stage.
- Accepts raw mode/increment key levels for time setting.
- Runs entirely in the 50 MHz clkin domain. The 1 kHz input is treated as data, not as a clock.

Parameters:
- TICKS_PER_SEC, 1000, number of tick_in rising edges per second; legal range 2..1023.
- SYNC_STAGES, 2, synchronizer flops on each asynchronous input (tick_in, key_mode, key_inc); minimum 2.

Ports:
- clkin  in  1  system clock, 50 MHz
- rst_N  in  1  asynchronous active-low reset
- tick_in  in  1  1 kHz square wave from the clock divider
- key_mode  in  1  raw mode key level, active-high
- key_inc  in  1  raw increment key level, active-high
- hour_bcd  out  8  hours, two BCD digits, [7:4] tens
- min_bcd  out  8  minutes, two BCD digits
- sec_bcd  out  8  seconds, two BCD digits
- set_mode  out  2  00 RUN, 01 SET_HR, 10 SET_MIN
- sec_pulse  out  1  one-cycle strobe on every seconds increment
- pm  out  1  PM indicator (see Optional Feature)

Behaviour:
- Reset is asynchronous, active-low.
  - Applies at any time, including mid-setting. Counters and sync chains are cleared immediately.
  - Reset values: hour/min/sec_bcd = 8'h00, set_mode = 00, sec_pulse = 0, pm = 0, ms counter = 0, all sync flops = 0.
  - A reset asserted during SET_HR or SET_MIN returns the block to RUN.
- Input conditioning:
  - Each input passes through SYNC_STAGES flops plus one history flop.
  - A rising edge produces a one-cycle internal pulse, registered SYNC_STAGES+1 clkin cycles after the input edge.
  - Falling edges are ignored.
- Tick counting (RUN only):
  - ms counter runs 0..TICKS_PER_SEC-1, width clog2(TICKS_PER_SEC).
  - A tick pulse at TICKS_PER_SEC-1 wraps the counter to 0 and generates a second carry.
  - sec_pulse is registered high in the cycle following that tick pulse.
- Time carry chain:
  - All digit updates happen in the same clock edge.
  - sec 59 -> 00 carries into min; min 59 -> 00 carries into hour; hour 23 -> 00.
  - 23:59:59 + 1 s = 00:00:00.
  - Units digit 9 -> 0 increments the tens digit.
  - Non-BCD values are unreachable and need no recovery.
- FSM:
  - RUN: a key_mode pulse moves to SET_HR.
  - SET_HR: key_mode moves to SET_MIN.
  - SET_MIN: key_mode moves to RUN, clears sec to 00 and the ms counter to 0 on that transition.
- Setting:
  - In SET_HR and SET_MIN the ms counter and seconds are frozen; tick pulses are discarded and sec_pulse stays 0.
  - key_inc in SET_HR: hour +1, wraps 23 -> 00.
  - key_inc in SET_MIN: min +1, wraps 59 -> 00, no carry into hour.
  - key_inc in RUN is ignored.
- Simultaneous events:
  - key_mode and key_inc pulses in the same cycle: mode wins and inc is dropped.
  - Tick pulse in the same cycle as a RUN -> SET_HR transition: the tick is discarded.
- Outputs are registered and change only on clkin edges.

Optional Feature:
- Macro: TIMEKEEPER_12H_EN.
- Defined:
  - Internal count remains 24 h. hour_bcd presents 12-hour form: internal 00 -> 12, 01..12 unchanged, 13..23 -> 01..11.
  - pm = 1 when internal hour >= 12.
  - SET_HR increments the internal hour, so the display goes 11 AM -> 12 PM -> 01 PM.
- Not defined: hour_bcd shows the internal 24-hour value and pm is tied to 0.

Decomposition:
- Shared package digiclock_pkg holds:
  - set_mode encoding constants (MODE_RUN, MODE_SET_HR, MODE_SET_MIN);
  - BCD limits (SEC_MAX 8'h59, MIN_MAX 8'h59, HOUR_MAX 8'h23);
  - default TICKS_PER_SEC.
- One sub-module, bcd_mod_counter:
  - two-digit BCD counter with parameter MAX, inputs inc/clr, output carry (asserted when inc at MAX).
  - Instantiated three times: sec, min, hour.
- Edge-detect synchronizers are inline.

Test Plan (TICKS_PER_SEC=4 unless noted):
- Reset, then 4 tick_in rising edges -> sec_bcd 8'h01, exactly one sec_pulse, set_mode 00; first sec_pulse appears SYNC_STAGES+2 cycles after the 4th edge.
- Preload to 23:59:58 via setting, then 8 ticks -> sequence 23:59:59 then 00:00:00; hour/min/sec all change on the same edge.
- key_mode, key_inc x3, key_mode, key_inc x61, key_mode -> hour 8'h03, min 8'h01 (59 -> 00 wraps without touching hour), sec 8'h00, set_mode 00; ticks in SET states do not advance sec.
- key_mode and key_inc rising on the same cycle in RUN -> set_mode 01, hour unchanged; key_inc pulse in RUN alone -> no change.
- Assert rst_N low mid-SET_MIN at 12:34 -> all outputs 0 asynchronously, before the next clkin edge; after release, RUN resumes counting from 00:00:00.
- TIMEKEEPER_12H_EN defined, set hour to 00, 12 and 13 -> hour_bcd/pm = 12/0, 12/1, 01/1.

Source files
------------

// File: rtl/digiclock_pkg.sv
// Shared constants, mode encoding and BCD helpers for the digital clock.
package digiclock_pkg;

    localparam int unsigned TICKS_PER_SEC_DEF = 1000;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'b00,
        MODE_SET_HR  = 2'b01,
        MODE_SET_MIN = 2'b10
    } mode_e;

    localparam logic [7:0] SEC_MAX  = 8'h59;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] HOUR_MAX = 8'h23;
    localparam logic [7:0] HOUR_PM  = 8'h12;

    // Two-digit BCD increment, wrapping to 00 after max_val.
    function automatic logic [7:0] bcd_next(input logic [7:0] val, input logic [7:0] max_val);
        logic [7:0] nxt;
        if (val == max_val) begin
            nxt = 8'h00;
        end else if (val[3:0] == 4'd9) begin
            nxt = {val[7:4] + 4'd1, 4'd0};
        end else begin
            nxt = {val[7:4], val[3:0] + 4'd1};
        end
        return nxt;
    endfunction

    // 24-hour BCD to 12-hour BCD (00 -> 12, 13..23 -> 01..11).
    function automatic logic [7:0] to_12h(input logic [7:0] h24);
        logic [4:0] bin;
        bin = 5'(h24[7:4]) * 5'd10 + 5'(h24[3:0]);
        if (bin == 5'd0) begin
            bin = 5'd12;
        end else if (bin > 5'd12) begin
            bin = bin - 5'd12;
        end
        return {4'(bin / 5'd10), 4'(bin % 5'd10)};
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter; carry flags the wrap from MAX to 00.
module bcd_mod_counter
    import digiclock_pkg::*;
#(
    parameter logic [7:0] MAX = 8'h59
) (
    input  logic       clkin,
    input  logic       rst_N,
    input  logic       inc,
    input  logic       clr,
    output logic [7:0] value,
    output logic       carry
);

    assign carry = inc && !clr && (value == MAX);

    always_ff @(posedge clkin or negedge rst_N) begin
        if (!rst_N) begin
            value <= 8'h00;
        end else if (clr) begin
            value <= 8'h00;
        end else if (inc) begin
            value <= bcd_next(value, MAX);
        end
    end

endmodule

// File: rtl/clock_timekeeper.sv
// Timekeeping stage: counts 1 kHz ticks into BCD hh:mm:ss with key-driven setting.
// Optional 12-hour display with PM flag when TIMEKEEPER_12H_EN is defined.
module clock_timekeeper
    import digiclock_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = TICKS_PER_SEC_DEF,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic       clkin,
    input  logic       rst_N,
    input  logic       tick_in,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic [1:0] set_mode,
    output logic       sec_pulse,
    output logic       pm
);

    localparam int unsigned MS_W = $clog2(TICKS_PER_SEC);
    localparam logic [MS_W-1:0] MS_LAST = MS_W'(TICKS_PER_SEC - 1);
    localparam int unsigned N_IN = 3;

    logic [N_IN-1:0]                  raw;
    logic [N_IN-1:0][SYNC_STAGES-1:0] sync_q;
    logic [N_IN-1:0]                  hist_q;
    logic [N_IN-1:0]                  pulse_q;
    logic                             tick_p, mode_p, inc_p;

    mode_e           state_q, state_nxt;
    logic [MS_W-1:0] ms_q;
    logic            run_tick_c, sec_inc_c, sec_clr_c, min_set_c, hr_set_c;
    logic            min_inc_c, hr_inc_c;
    logic            sec_carry, min_carry, hour_carry_unused;
    logic [7:0]      hour_q;

    assign raw = {key_inc, key_mode, tick_in};

    // Synchronize each raw input, then register a one-cycle rising-edge pulse.
    always_ff @(posedge clkin or negedge rst_N) begin
        if (!rst_N) begin
            sync_q  <= '0;
            hist_q  <= '0;
            pulse_q <= '0;
        end else begin
            for (int i = 0; i < int'(N_IN); i++) begin
                sync_q[i]  <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
                hist_q[i]  <= sync_q[i][SYNC_STAGES-1];
                pulse_q[i] <= sync_q[i][SYNC_STAGES-1] & ~hist_q[i];
            end
        end
    end

    assign tick_p = pulse_q[0];
    assign mode_p = pulse_q[1];
    assign inc_p  = pulse_q[2];

    always_ff @(posedge clkin or negedge rst_N) begin
        if (!rst_N) begin
            state_q <= MODE_RUN;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        if (mode_p) begin
            case (state_q)
                MODE_RUN:     state_nxt = MODE_SET_HR;
                MODE_SET_HR:  state_nxt = MODE_SET_MIN;
                MODE_SET_MIN: state_nxt = MODE_RUN;
                default:      state_nxt = MODE_RUN;
            endcase
        end
    end

    // A mode pulse always wins: it suppresses a coincident tick or increment.
    always_comb begin
        run_tick_c = 1'b0;
        sec_clr_c  = 1'b0;
        min_set_c  = 1'b0;
        hr_set_c   = 1'b0;
        case (state_q)
            MODE_RUN:     run_tick_c = tick_p && !mode_p;
            MODE_SET_HR:  hr_set_c   = inc_p && !mode_p;
            MODE_SET_MIN: begin
                min_set_c = inc_p && !mode_p;
                sec_clr_c = mode_p;
            end
            default: ;
        endcase
        sec_inc_c = run_tick_c && (ms_q == MS_LAST);
        min_inc_c = sec_carry || min_set_c;
        hr_inc_c  = (sec_carry && min_carry) || hr_set_c;
    end

    always_ff @(posedge clkin or negedge rst_N) begin
        if (!rst_N) begin
            ms_q      <= '0;
            sec_pulse <= 1'b0;
        end else begin
            sec_pulse <= sec_inc_c;
            if (sec_clr_c) begin
                ms_q <= '0;
            end else if (run_tick_c) begin
                ms_q <= (ms_q == MS_LAST) ? '0 : ms_q + MS_W'(1);
            end
        end
    end

    bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
        .clkin (clkin),
        .rst_N (rst_N),
        .inc   (sec_inc_c),
        .clr   (sec_clr_c),
        .value (sec_bcd),
        .carry (sec_carry)
    );

    bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
        .clkin (clkin),
        .rst_N (rst_N),
        .inc   (min_inc_c),
        .clr   (1'b0),
        .value (min_bcd),
        .carry (min_carry)
    );

    bcd_mod_counter #(.MAX(HOUR_MAX)) u_hour (
        .clkin (clkin),
        .rst_N (rst_N),
        .inc   (hr_inc_c),
        .clr   (1'b0),
        .value (hour_q),
        .carry (hour_carry_unused)
    );

    assign set_mode = state_q;

`ifdef TIMEKEEPER_12H_EN
    logic [7:0] hour_nxt_c;

    assign hour_nxt_c = hr_inc_c ? bcd_next(hour_q, HOUR_MAX) : hour_q;

    // Display tracks the hour counter's next value so it moves on the same edge.
    always_ff @(posedge clkin or negedge rst_N) begin
        if (!rst_N) begin
            hour_bcd <= 8'h00;
            pm       <= 1'b0;
        end else begin
            hour_bcd <= to_12h(hour_nxt_c);
            pm       <= (hour_nxt_c >= HOUR_PM);
        end
    end
`else
    assign hour_bcd = hour_q;
    assign pm       = 1'b0;
`endif

endmodule

// File: tb/tb_clock_timekeeper.sv
// Self-checking bench for clock_timekeeper (TICKS_PER_SEC=4, SYNC_STAGES=2).
module tb_clock_timekeeper;

    localparam int TPS      = 4;
    localparam int SYNC     = 2;
    localparam int HIGH_CYC = 3;
    localparam int LOW_CYC  = 4;
    localparam int OP_TICK  = 0;
    localparam int OP_MODE  = 1;
    localparam int OP_INC   = 2;
    localparam int N_VEC    = 17;

    logic       clkin    = 1'b0;
    logic       rst_N    = 1'b0;
    logic       tick_in  = 1'b0;
    logic       key_mode = 1'b0;
    logic       key_inc  = 1'b0;
    logic [7:0] hour_bcd, min_bcd, sec_bcd;
    logic [1:0] set_mode;
    logic       sec_pulse, pm;

    clock_timekeeper #(
        .TICKS_PER_SEC (TPS),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .clkin     (clkin),
        .rst_N     (rst_N),
        .tick_in   (tick_in),
        .key_mode  (key_mode),
        .key_inc   (key_inc),
        .hour_bcd  (hour_bcd),
        .min_bcd   (min_bcd),
        .sec_bcd   (sec_bcd),
        .set_mode  (set_mode),
        .sec_pulse (sec_pulse),
        .pm        (pm)
    );

    always #5 clkin = ~clkin;

    typedef struct {
        int h;
        int m;
        int s;
    } tstamp_t;

    typedef struct {
        int op;
        int n;
        int h;
        int m;
        int s;
        int md;
    } vec_t;

    int      checks = 0;
    int      errors = 0;
    int      m_h = 0, m_m = 0, m_s = 0, m_ms = 0, m_mode = 0;
    int      exp_pulses = 0;
    int      seen_pulses = 0;
    tstamp_t sb[$];
    vec_t    vec[N_VEC];

    function automatic logic [7:0] bcd8(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] exp_hr(input int h);
`ifdef TIMEKEEPER_12H_EN
        int hh;
        hh = (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
        return bcd8(hh);
`else
        return bcd8(h);
`endif
    endfunction

    function automatic logic [7:0] exp_pm(input int h);
`ifdef TIMEKEEPER_12H_EN
        return (h >= 12) ? 8'd1 : 8'd0;
`else
        return (h < 0) ? 8'd1 : 8'd0;
`endif
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input int h, input int m, input int s, input int md);
        check({tag, ".hour"}, hour_bcd, exp_hr(h));
        check({tag, ".min"},  min_bcd,  bcd8(m));
        check({tag, ".sec"},  sec_bcd,  bcd8(s));
        check({tag, ".mode"}, 8'(set_mode), 8'(md));
        check({tag, ".pm"},   8'(pm), exp_pm(h));
    endtask

    // Reference model: advances when stimulus is driven, queues each expected second.
    task automatic model_sec();
        m_s++;
        if (m_s == 60) begin
            m_s = 0;
            m_m++;
            if (m_m == 60) begin
                m_m = 0;
                m_h = (m_h + 1) % 24;
            end
        end
        exp_pulses++;
        sb.push_back('{h: m_h, m: m_m, s: m_s});
    endtask

    task automatic model_event(input bit t, input bit md, input bit ic);
        if (md) begin
            if (m_mode == 2) begin
                m_s  = 0;
                m_ms = 0;
            end
            m_mode = (m_mode + 1) % 3;
        end else begin
            if (t && m_mode == 0) begin
                if (m_ms == TPS - 1) begin
                    m_ms = 0;
                    model_sec();
                end else begin
                    m_ms++;
                end
            end
            if (ic && m_mode == 1) m_h = (m_h + 1) % 24;
            if (ic && m_mode == 2) m_m = (m_m + 1) % 60;
        end
    endtask

    task automatic pulse(input bit t, input bit md, input bit ic);
        @(negedge clkin);
        tick_in  = t;
        key_mode = md;
        key_inc  = ic;
        model_event(t, md, ic);
        repeat (HIGH_CYC) @(negedge clkin);
        tick_in  = 1'b0;
        key_mode = 1'b0;
        key_inc  = 1'b0;
        repeat (LOW_CYC) @(negedge clkin);
    endtask

    task automatic apply(input int op, input int n);
        repeat (n) pulse(op == OP_TICK, op == OP_MODE, op == OP_INC);
    endtask

    // Scoreboard consumer: every sec_pulse must match the oldest queued time.
    always @(negedge clkin) begin
        if (rst_N && sec_pulse) begin
            tstamp_t e;
            seen_pulses++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: actual=sec_pulse at %0h:%0h:%0h required=no pulse",
                         hour_bcd, min_bcd, sec_bcd);
            end else begin
                e = sb.pop_front();
                check("sb.hour", hour_bcd, exp_hr(e.h));
                check("sb.min",  min_bcd,  bcd8(e.m));
                check("sb.sec",  sec_bcd,  bcd8(e.s));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first_k, npulse, mixed, seen;

        vec[0]  = '{OP_INC,    1,  0,  0,  1, 0};
        vec[1]  = '{OP_MODE,   1,  0,  0,  1, 1};
        vec[2]  = '{OP_TICK,   8,  0,  0,  1, 1};
        vec[3]  = '{OP_INC,    3,  3,  0,  1, 1};
        vec[4]  = '{OP_MODE,   1,  3,  0,  1, 2};
        vec[5]  = '{OP_TICK,   4,  3,  0,  1, 2};
        vec[6]  = '{OP_INC,   61,  3,  1,  1, 2};
        vec[7]  = '{OP_MODE,   1,  3,  1,  0, 0};
        vec[8]  = '{OP_TICK,   4,  3,  1,  1, 0};
        vec[9]  = '{OP_MODE,   1,  3,  1,  1, 1};
        vec[10] = '{OP_INC,   20, 23,  1,  1, 1};
        vec[11] = '{OP_MODE,   1, 23,  1,  1, 2};
        vec[12] = '{OP_INC,   58, 23, 59,  1, 2};
        vec[13] = '{OP_MODE,   1, 23, 59,  0, 0};
        vec[14] = '{OP_TICK, 232, 23, 59, 58, 0};
        vec[15] = '{OP_TICK,   4, 23, 59, 59, 0};
        vec[16] = '{OP_TICK,   3, 23, 59, 59, 0};

        // Reset state
        repeat (2) @(negedge clkin);
        check("rst.hour",  hour_bcd, 8'h00);
        check("rst.min",   min_bcd,  8'h00);
        check("rst.sec",   sec_bcd,  8'h00);
        check("rst.mode",  8'(set_mode), 8'h00);
        check("rst.pulse", 8'(sec_pulse), 8'h00);
        check("rst.pm",    8'(pm), 8'h00);
        rst_N = 1'b1;

        // First second and its pulse latency after the 4th tick edge
        apply(OP_TICK, 3);
        @(negedge clkin);
        tick_in = 1'b1;
        model_event(1'b1, 1'b0, 1'b0);
        first_k = 0;
        npulse  = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clkin);
            if (sec_pulse) begin
                npulse++;
                if (first_k == 0) first_k = k;
            end
            if (k == HIGH_CYC) tick_in = 1'b0;
        end
        check_int("first_pulse_latency", first_k, SYNC + 2);
        check_int("first_pulse_count", npulse, 1);
        check_state("first_sec", 0, 0, 1, 0);

        // Table-driven vectors: setting, frozen ticks, wraps, preload to 23:59:59
        for (int i = 0; i < N_VEC; i++) begin
            apply(vec[i].op, vec[i].n);
            check_state($sformatf("vec%0d", i), vec[i].h, vec[i].m, vec[i].s, vec[i].md);
        end

        // Midnight rollover: hour, min and sec must change on one edge
        @(negedge clkin);
        tick_in = 1'b1;
        model_event(1'b1, 1'b0, 1'b0);
        mixed = 0;
        seen  = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clkin);
            if (sec_pulse) seen++;
            if (!((hour_bcd == exp_hr(23) && min_bcd == 8'h59 && sec_bcd == 8'h59) ||
                  (hour_bcd == exp_hr(0) && min_bcd == 8'h00 && sec_bcd == 8'h00)))
                mixed++;
            if (k == HIGH_CYC) tick_in = 1'b0;
        end
        check_int("midnight_mixed_cycles", mixed, 0);
        check_int("midnight_pulse", seen, 1);
        check_state("midnight", 0, 0, 0, 0);

        // Tick+mode+inc together at ms=TPS-1: mode wins, tick and inc dropped
        apply(OP_TICK, 3);
        pulse(1'b1, 1'b1, 1'b1);
        check_state("simul", 0, 0, 0, 1);
        apply(OP_MODE, 2);
        check_state("back_to_run", 0, 0, 0, 0);
        apply(OP_TICK, 3);
        check_state("ms_cleared", 0, 0, 0, 0);
        apply(OP_TICK, 1);
        check_state("ms_cleared_sec", 0, 0, 1, 0);

        // Asynchronous reset in the middle of SET_MIN at 12:34
        apply(OP_MODE, 1);
        apply(OP_INC, 12);
        apply(OP_MODE, 1);
        apply(OP_INC, 34);
        check_state("pre_reset", 12, 34, 1, 2);
        @(posedge clkin);
        #2;
        rst_N = 1'b0;
        #1;
        check("async_rst.hour",  hour_bcd, 8'h00);
        check("async_rst.min",   min_bcd,  8'h00);
        check("async_rst.sec",   sec_bcd,  8'h00);
        check("async_rst.mode",  8'(set_mode), 8'h00);
        check("async_rst.pulse", 8'(sec_pulse), 8'h00);
        check("async_rst.pm",    8'(pm), 8'h00);
        m_h = 0; m_m = 0; m_s = 0; m_ms = 0; m_mode = 0;
        repeat (2) @(negedge clkin);
        rst_N = 1'b1;
        apply(OP_TICK, 4);
        check_state("post_reset", 0, 0, 1, 0);

        repeat (4) @(negedge clkin);
        check_int("sb_empty", sb.size(), 0);
        check_int("sec_pulse_total", seen_pulses, exp_pulses);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
